// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges execute jumps, divider occupancy, bus stalls and IRQ entry into hold/flush/redirect.
// Latency: redirect/ack/hold/flush are combinational in the decision cycle; state and counters update on clk.
// Backpressure: bus_hold_i stalls PC/if_id only; optional watchdog under PIPE_CTRL_DIV_TIMEOUT_EN.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DIV_TIMEOUT  = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        div_start_i,
    input  logic        div_ready_i,
    input  logic        bus_hold_i,
    input  logic        irq_req_i,
    input  logic [31:0] irq_addr_i,
    output logic        irq_ack_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_o,
    output logic        hold_id_o,
    output logic        flush_o,
    output logic        div_timeout_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_BUSY = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_t      state;
    logic [2:0]  flush_cnt;
    logic        redirect;
    logic [31:0] redir_addr;
    logic        ack;
    logic        hold_core;
    logic        flush;
    logic        timeout;
    logic        timeout_hit;

`ifdef PIPE_CTRL_DIV_TIMEOUT_EN
    logic [7:0] div_cnt;
    assign timeout_hit = (div_cnt == 8'(DIV_TIMEOUT));
`else
    logic unused_div_limit;
    assign unused_div_limit = ^8'(DIV_TIMEOUT);
    assign timeout_hit      = 1'b0;
`endif

    always_comb begin
        redirect   = 1'b0;
        redir_addr = 32'd0;
        ack        = 1'b0;
        hold_core  = 1'b0;
        flush      = 1'b0;
        timeout    = 1'b0;
        case (state)
            RUN: begin
                if (jump_flag_i) begin
                    redirect   = 1'b1;
                    redir_addr = jump_addr_i;
                    flush      = 1'b1;
                end else if (div_start_i) begin
                    hold_core  = 1'b1;
                end else if (irq_req_i) begin
                    ack        = 1'b1;
                    redirect   = 1'b1;
                    redir_addr = irq_addr_i;
                    flush      = 1'b1;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (jump_flag_i) begin
                    redirect   = 1'b1;
                    redir_addr = jump_addr_i;
                end
            end
            DIV_BUSY: begin
                // A jump is only meaningful once the divider result is written back.
                if (div_ready_i) begin
                    if (jump_flag_i) begin
                        redirect   = 1'b1;
                        redir_addr = jump_addr_i;
                        flush      = 1'b1;
                    end
                end else begin
                    hold_core = 1'b1;
                    timeout   = timeout_hit;
                end
            end
            default: ;
        endcase
    end

    // Outputs are gated by reset so an asserted reset silences them without waiting for a clock.
    assign irq_ack_o     = rst & ack;
    assign jump_flag_o   = rst & redirect;
    assign jump_addr_o   = rst ? redir_addr : 32'd0;
    assign hold_pc_o     = rst & (hold_core | bus_hold_i);
    assign hold_if_o     = rst & (hold_core | bus_hold_i);
    assign hold_id_o     = rst & hold_core;
    assign flush_o       = rst & flush;
    assign div_timeout_o = rst & timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
`ifdef PIPE_CTRL_DIV_TIMEOUT_EN
            div_cnt   <= 8'd0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        if (MULTI_FLUSH) begin
                            state     <= FLUSH;
                            flush_cnt <= FLUSH_RELOAD;
                        end
                    end else if (div_start_i) begin
                        state   <= DIV_BUSY;
`ifdef PIPE_CTRL_DIV_TIMEOUT_EN
                        div_cnt <= 8'd1;
`endif
                    end
                end
                FLUSH: begin
                    if (redirect) begin
                        flush_cnt <= FLUSH_RELOAD;
                    end else if (flush_cnt <= 3'd1) begin
                        state     <= RUN;
                        flush_cnt <= 3'd0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                DIV_BUSY: begin
                    if (redirect && MULTI_FLUSH) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_RELOAD;
                    end else if (div_ready_i || timeout_hit) begin
                        state <= RUN;
                    end
`ifdef PIPE_CTRL_DIV_TIMEOUT_EN
                    div_cnt <= (div_ready_i || timeout_hit) ? 8'd0 : div_cnt + 8'd1;
`endif
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, multi-cycle sequences and a randomized run against a reference model.
module tb_pipe_ctrl;

    localparam int FC = 2;
    localparam int DT = 40;
`ifdef PIPE_CTRL_DIV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i, div_start_i, div_ready_i, bus_hold_i, irq_req_i;
    logic [31:0] jump_addr_i, irq_addr_i;
    logic        irq_ack_o, jump_flag_o, hold_pc_o, hold_if_o, hold_id_o, flush_o, div_timeout_o;
    logic [31:0] jump_addr_o;

    int checks = 0;
    int errors = 0;
    logic to_seen = 1'b0;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .DIV_TIMEOUT(DT)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .div_start_i(div_start_i), .div_ready_i(div_ready_i),
        .bus_hold_i(bus_hold_i), .irq_req_i(irq_req_i), .irq_addr_i(irq_addr_i),
        .irq_ack_o(irq_ack_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
        .hold_pc_o(hold_pc_o), .hold_if_o(hold_if_o), .hold_id_o(hold_id_o),
        .flush_o(flush_o), .div_timeout_o(div_timeout_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (div_timeout_o) to_seen <= 1'b1;

    // flag order: ack, jump_flag, hold_pc, hold_if, hold_id, flush, div_timeout
    wire [6:0] act = {irq_ack_o, jump_flag_o, hold_pc_o, hold_if_o, hold_id_o, flush_o, div_timeout_o};

    typedef struct {
        logic        j;
        logic [31:0] ja;
        logic        ds;
        logic        dr;
        logic        bh;
        logic        irq;
        logic [31:0] ia;
        logic [6:0]  ev;
        logic [31:0] ea;
    } vec_t;

    vec_t vecs [17];

    // Reference model: remaining flush cycles, divider activity and age since issue.
    bit m_div;
    int m_age;
    int m_flush_rem;

    task automatic chk(input string nm, input logic [6:0] ev, input logic [31:0] ea);
        checks++;
        if (act !== ev || jump_addr_o !== ea) begin
            errors++;
            $display("FAIL %s: got flags=%b addr=%h, expected flags=%b addr=%h", nm, act, jump_addr_o, ev, ea);
        end
    endtask

    task automatic drive(input logic j, input logic [31:0] ja, input logic ds, input logic dr,
                         input logic bh, input logic irq, input logic [31:0] ia);
        jump_flag_i = j;  jump_addr_i = ja;
        div_start_i = ds; div_ready_i = dr;
        bus_hold_i  = bh; irq_req_i   = irq; irq_addr_i = ia;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        next_cycle();
        m_div = 0; m_age = 0; m_flush_rem = 0;
    endtask

    task automatic model(input logic j, input logic [31:0] ja, input logic ds, input logic dr,
                         input logic bh, input logic irq, input logic [31:0] ia,
                         output logic [6:0] ev, output logic [31:0] ea);
        logic red, ack, hold, fl, to;
        red = 0; ack = 0; hold = 0; fl = 0; to = 0; ea = 0;
        if (m_div) begin
            if (dr) begin
                if (j) begin red = 1; ea = ja; end
                m_div = 0;
            end else begin
                hold = 1;
                if (TO_EN && m_age == DT) begin to = 1; m_div = 0; end
                else m_age++;
            end
        end else if (m_flush_rem > 0) begin
            fl = 1;
            if (j) begin red = 1; ea = ja; end
            else m_flush_rem--;
        end else begin
            if (j) begin red = 1; ea = ja; end
            else if (ds) begin hold = 1; m_div = 1; m_age = 1; end
            else if (irq) begin red = 1; ack = 1; ea = ia; end
        end
        if (red) begin fl = 1; m_flush_rem = FC - 1; end
        ev = {ack, red, hold | bh, hold | bh, hold, fl, to};
    endtask

    initial begin
        logic [6:0]  ev;
        logic [31:0] ea;
        logic j, ds, dr, bh, irq;
        logic [31:0] ja, ia;

        vecs[0]  = '{1, 32'h100, 0, 0, 0, 0, 32'h0, 7'b0100010, 32'h100};
        vecs[1]  = '{0, 32'h0,   0, 0, 0, 0, 32'h0, 7'b0000010, 32'h0};
        vecs[2]  = '{0, 32'h0,   0, 0, 0, 0, 32'h0, 7'b0000000, 32'h0};
        vecs[3]  = '{1, 32'h40,  0, 0, 0, 1, 32'h8, 7'b0100010, 32'h40};
        vecs[4]  = '{0, 32'h0,   0, 0, 1, 1, 32'h8, 7'b0011010, 32'h0};
        vecs[5]  = '{0, 32'h0,   0, 0, 0, 1, 32'h8, 7'b1100010, 32'h8};
        vecs[6]  = '{0, 32'h0,   0, 0, 0, 0, 32'h0, 7'b0000010, 32'h0};
        vecs[7]  = '{0, 32'h0,   0, 0, 0, 0, 32'h0, 7'b0000000, 32'h0};
        vecs[8]  = '{1, 32'h10,  0, 0, 0, 0, 32'h0, 7'b0100010, 32'h10};
        vecs[9]  = '{1, 32'h20,  0, 0, 0, 0, 32'h0, 7'b0100010, 32'h20};
        vecs[10] = '{0, 32'h0,   0, 0, 0, 0, 32'h0, 7'b0000010, 32'h0};
        vecs[11] = '{0, 32'h0,   0, 0, 0, 0, 32'h0, 7'b0000000, 32'h0};
        vecs[12] = '{0, 32'h0,   1, 0, 0, 1, 32'h8, 7'b0011100, 32'h0};
        vecs[13] = '{1, 32'h30,  0, 0, 0, 1, 32'h8, 7'b0011100, 32'h0};
        vecs[14] = '{0, 32'h0,   0, 1, 1, 0, 32'h0, 7'b0011000, 32'h0};
        vecs[15] = '{0, 32'h0,   0, 0, 0, 0, 32'h0, 7'b0000000, 32'h0};
        vecs[16] = '{0, 32'h0,   0, 0, 1, 0, 32'h0, 7'b0011000, 32'h0};

        rst = 1'b0;
        drive(1, 32'hdead_beef, 1, 0, 1, 1, 32'h8);
        #3;
        chk("reset_outputs", 7'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        next_cycle();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].j, vecs[i].ja, vecs[i].ds, vecs[i].dr, vecs[i].bh, vecs[i].irq, vecs[i].ia);
            #3;
            chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea);
            next_cycle();
        end

        // Divider stall ending in a redirect from write-back.
        for (int c = 0; c <= 35; c++) begin
            if (c == 0)       drive(0, 0, 1, 0, 0, 0, 0);
            else if (c == 33) drive(1, 32'h204, 0, 1, 0, 0, 0);
            else              drive(0, 0, 0, 0, 0, 0, 0);
            #3;
            if (c <= 32)      chk($sformatf("div_hold_c%0d", c), 7'b0011100, 32'h0);
            else if (c == 33) chk("div_redirect", 7'b0100010, 32'h204);
            else if (c == 34) chk("div_flush_tail", 7'b0000010, 32'h0);
            else              chk("div_back_run", 7'b0000000, 32'h0);
            next_cycle();
        end

        // Reset asserted mid-divide.
        to_seen = 1'b0;
        drive(0, 0, 1, 0, 0, 0, 0);
        next_cycle();
        for (int c = 1; c < 10; c++) next_cycle();
        drive(1, 32'h55, 0, 0, 1, 1, 32'h8);
        #2;
        rst = 1'b0;
        #1;
        chk("reset_mid_div", 7'b0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        #3;
        chk("after_reset_idle", 7'b0, 32'h0);
        next_cycle();
        drive(1, 32'h77, 0, 0, 0, 0, 0);
        #3;
        chk("after_reset_jump", 7'b0100010, 32'h77);
        next_cycle();
`ifndef PIPE_CTRL_DIV_TIMEOUT_EN
        checks++;
        if (to_seen !== 1'b0) begin
            errors++;
            $display("FAIL div_timeout_never: got %b, expected 0", to_seen);
        end
`else
        do_reset();
        for (int c = 0; c <= 41; c++) begin
            drive(0, 0, (c == 0), 0, 0, 0, 0);
            #3;
            if (c < DT)       chk($sformatf("wd_hold_c%0d", c), 7'b0011100, 32'h0);
            else if (c == DT) chk("wd_fire", 7'b0011101, 32'h0);
            else              chk("wd_release", 7'b0000000, 32'h0);
            next_cycle();
        end
`endif

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            j   = ($urandom % 5) == 0;
            ds  = ($urandom % 6) == 0;
            dr  = ($urandom % 8) == 0;
            bh  = ($urandom % 4) == 0;
            irq = ($urandom % 4) == 0;
            ja  = $urandom;
            ia  = $urandom;
            drive(j, ja, ds, dr, bh, irq, ia);
            #3;
            model(j, ja, ds, dr, bh, irq, ia, ev, ea);
            chk($sformatf("rand%0d", n), ev, ea);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer for the tiny_riscv core. It sits beside the decode and execute stages and owns every stall and redirect in the pipeline. It merges four sources into one consistent set of hold, flush and PC-redirect controls for pc_reg, if_id and id_ex:

- execute-stage jumps (branches, JAL/JALR, FENCE and divider write-back jumps),
- multi-cycle divider occupancy,
- bus stalls,
- CLINT interrupt entry.

## Interface
- FLUSH_CYCLES, 2, flush_o width in cycles after a redirect (1–7).
- DIV_TIMEOUT, 40, max DIV_BUSY cycles before the watchdog fires (2–255).

- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-low
- jump_flag_i  in  1  execute requests a redirect
- jump_addr_i  in  32  execute redirect target
- div_start_i  in  1  execute issues DIV/DIVU/REM/REMU this cycle
- div_ready_i  in  1  divider result valid this cycle
- bus_hold_i  in  1  bus arbiter stalls fetch
- irq_req_i  in  1  CLINT interrupt request, level
- irq_addr_i  in  32  trap vector
- irq_ack_o  out  1  interrupt accepted, 1-cycle pulse
- jump_flag_o  out  1  redirect to pc_reg
- jump_addr_o  out  32  redirect target
- hold_pc_o  out  1  freeze PC
- hold_if_o  out  1  freeze if_id
- hold_id_o  out  1  freeze id_ex
- flush_o  out  1  load NOP into if_id/id_ex
- div_timeout_o  out  1  watchdog fired, 1-cycle pulse

## Operation
**States**
- RUN (reset state), DIV_BUSY, FLUSH.
- Counters: flush_cnt, 3 bits; div_cnt, 8 bits.

**RUN priority:** jump_flag_i > div_start_i > irq_req_i.
- jump_flag_i:
  - jump_flag_o=1, jump_addr_o=jump_addr_i, flush_o=1.
  - If FLUSH_CYCLES>1: go to FLUSH with flush_cnt=FLUSH_CYCLES-1.
  - If FLUSH_CYCLES=1: stay in RUN.
- div_start_i (no jump):
  - hold_pc/if/id=1 in the same cycle.
  - Go to DIV_BUSY with div_cnt=1.
- irq_req_i (no jump, no div_start):
  - irq_ack_o=1, jump_flag_o=1, jump_addr_o=irq_addr_i, flush_o=1.
  - Next state follows the same FLUSH rule as a jump.

**FLUSH**
- flush_o=1.
- flush_cnt decrements each cycle; go to RUN in the cycle it reaches 1.
- jump_flag_i in FLUSH redirects again and reloads flush_cnt=FLUSH_CYCLES-1.
- irq_req_i and div_start_i are ignored in FLUSH. An interrupt is deferred until RUN.

**DIV_BUSY**
- hold_pc/if/id=1 and div_cnt increments.
- div_ready_i:
  - All holds drop in that cycle.
  - If jump_flag_i is also high, the redirect is taken as in RUN and the next state follows the FLUSH rule.
  - Otherwise go to RUN.
- jump_flag_i without div_ready_i is ignored.
- irq_req_i is ignored.

**Bus stall**
- bus_hold_i ORs into hold_pc_o and hold_if_o in every state.
- It never affects hold_id_o, flush_o or the state.

**Outputs**
- When no redirect is taken, jump_addr_o=0.

## Timing
- **Reset:** all outputs 0, state RUN, both counters 0. Reset asserted mid-operation forces outputs to 0 immediately and aborts DIV_BUSY/FLUSH.
- **Combinational paths:**
  - Redirect, ack, hold and flush are combinational from inputs in the decision cycle: zero latency.
  - State and counters update on the rising clk edge.
- **Flush length:** flush_o is high for exactly FLUSH_CYCLES consecutive cycles per redirect. A re-redirect extends it.
- **Divider hold:** holds are high from the div_start_i cycle through the cycle before div_ready_i.
- **irq_ack_o:** asserted for exactly one cycle per accepted request. A request held high is re-acked only after FLUSH ends.
- **Combined stall:** div_ready_i and bus_hold_i in the same cycle give hold_id_o=0 and hold_pc/if=1.

## Configuration
- **PIPE_CTRL_DIV_TIMEOUT_EN defined:**
  - In DIV_BUSY, when div_cnt==DIV_TIMEOUT and div_ready_i=0: div_timeout_o=1 and holds stay 1 for that cycle.
  - Next state is RUN.
- **Undefined:**
  - DIV_BUSY waits indefinitely for div_ready_i.
  - div_timeout_o is tied 0 and the div_cnt logic is removed.

## Test plan
- **Jump redirect:** reset, then jump_flag_i=1 with jump_addr_i=0x0000_0100 for one cycle → jump_flag_o=1 and addr 0x100 in the same cycle; flush_o high for 2 cycles; back in RUN.
- **Divider stall:** div_start_i at cycle 0, div_ready_i+jump_flag_i at cycle 33 with addr 0x204 → hold_pc/if/id high for cycles 0–32; redirect to 0x204 at cycle 33; flush for cycles 33–34.
- **Interrupt vs jump:** irq_req_i=1 (irq_addr_i=0x8) together with jump_flag_i (0x40) → redirect to 0x40, irq_ack_o=0; ack plus redirect to 0x8 in the first RUN cycle after the flush.
- **Bus hold during flush:** bus_hold_i=1 during FLUSH → hold_pc/if=1, hold_id=0, flush_o unaffected.
- **Watchdog (macro defined):** div_start_i, no div_ready_i → div_timeout_o pulse at DIV_BUSY cycle 40; holds released the next cycle.
- **Reset mid-divide (macro undefined):** rst low at DIV_BUSY cycle 10 → all outputs 0 immediately; after release, state is RUN and div_timeout_o has never asserted.
